prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 27 ++
 rtl/prog_loader_word_assembler.sv | 33 +++
 rtl/prog_loader.sv | 110 +++++++++++
 tb/tb_prog_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: state encoding, byte-order and checksum constants.
package prog_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

    // Checksum starts from zero and folds in every program byte with XOR
    localparam logic [BYTE_W-1:0] CHK_INIT = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } state_t;

    function automatic logic [BYTE_W-1:0] chk_update(
        input logic [BYTE_W-1:0] chk,
        input logic [BYTE_W-1:0] data
    );
        return chk ^ data;
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects big-endian bytes into 32-bit words; the completed word is presented
// combinationally on the edge that accepts its fourth byte.
module prog_loader_word_assembler
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word_c,
    output logic              word_strobe_c
);

    localparam int unsigned HOLD_W = WORD_W - BYTE_W;

    logic [HOLD_W-1:0] shreg;
    logic [BCNT_W-1:0] bcnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shreg <= '0;
            bcnt  <= '0;
        end else if (byte_valid) begin
            shreg <= {shreg[HOLD_W-BYTE_W-1:0], byte_data};
            bcnt  <= bcnt + BCNT_W'(1);
        end
    end

    assign word_c        = {shreg, byte_data};
    assign word_strobe_c = byte_valid && (bcnt == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles RAM_SIZE words, verifies an XOR
// checksum, then releases the downstream CPU from reset.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned RAM_SIZE = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       rx_valid,
    input  logic [BYTE_W-1:0]          rx_data,
    output logic                       rx_ready,
    output logic [RAM_SIZE*WORD_W-1:0] ram,
    output logic                       cpu_reset,
    output logic                       done,
    output logic                       error,
    output logic [7:0]                 word_count
);

    localparam int unsigned IDX_W = $clog2(RAM_SIZE) + 1;

    state_t            state;
    state_t            state_nxt;
    logic              clear_c;
    logic              accept_c;
    logic              load_byte_c;
    logic              last_word_c;
    logic [IDX_W-1:0]  word_idx;
    logic [BYTE_W-1:0] checksum;
    logic [WORD_W-1:0] word_c;
    logic              word_strobe_c;

    assign accept_c    = rx_valid && rx_ready;
    assign load_byte_c = accept_c && (state == ST_LOAD);
    assign last_word_c = word_strobe_c && (word_idx == IDX_W'(RAM_SIZE - 1));

    prog_loader_word_assembler u_asm (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear_c),
        .byte_valid    (load_byte_c),
        .byte_data     (rx_data),
        .word_c        (word_c),
        .word_strobe_c (word_strobe_c)
    );

    // Next-state logic; start only matters outside an active load
    always_comb begin
        state_nxt = state;
        clear_c   = 1'b0;
        unique case (state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    clear_c   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (last_word_c) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (accept_c) begin
                    state_nxt = (rx_data == checksum) ? ST_RUN : ST_ERROR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, registered status flags and the program image
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rx_ready  <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            ram       <= '0;
            word_idx  <= '0;
            checksum  <= CHK_INIT;
        end else begin
            state     <= state_nxt;
            rx_ready  <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
            cpu_reset <= (state_nxt != ST_RUN);
            done      <= (state_nxt == ST_RUN);
            error     <= (state_nxt == ST_ERROR);
            if (clear_c) begin
                ram      <= '0;
                word_idx <= '0;
                checksum <= CHK_INIT;
            end else if (load_byte_c) begin
                checksum <= chk_update(checksum, rx_data);
                if (word_strobe_c && (word_idx < IDX_W'(RAM_SIZE))) begin
                    for (int i = 0; i < int'(RAM_SIZE); i++) begin
                        if (word_idx == IDX_W'(i)) begin
                            ram[i*WORD_W +: WORD_W] <= word_c;
                        end
                    end
                    word_idx <= word_idx + IDX_W'(1);
                end
            end
        end
    end

    assign word_count = 8'(word_idx);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed and random loads against a byte-list model.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int unsigned RAM_SIZE = 4;
    localparam int unsigned RAM_W    = RAM_SIZE * 32;
    localparam int unsigned NBYTES   = RAM_SIZE * 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic [RAM_W-1:0] ram;
    logic             cpu_reset;
    logic             done;
    logic             error;
    logic [7:0]       word_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [RAM_W-1:0] ram;
        logic             ok;
        int               wc;
    } exp_t;

    exp_t exp_q[$];
    logic flag_q = 1'b0;

    prog_loader #(.RAM_SIZE(RAM_SIZE)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .ram        (ram),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [RAM_W-1:0] act, input logic [RAM_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Image holding only the complete words among the first n bytes
    function automatic logic [RAM_W-1:0] image(input logic [7:0] b[$], input int n);
        logic [RAM_W-1:0] img = '0;
        for (int w = 0; w < int'(RAM_SIZE); w++) begin
            if (4 * w + 3 < n) begin
                img[w*32 +: 32] = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
            end
        end
        return img;
    endfunction

    function automatic logic [7:0] xor_all(input logic [7:0] b[$]);
        logic [7:0] x = CHK_INIT;
        foreach (b[i]) x = x ^ b[i];
        return x;
    endfunction

    // Monitor: every new done/error outcome is scored against the queue head
    always @(negedge clk) begin
        exp_t e;
        if ((done || error) && !flag_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_outcome actual done=%0b error=%0b required none", done, error);
            end else begin
                e = exp_q.pop_front();
                check("out_done", RAM_W'(done), RAM_W'(e.ok));
                check("out_error", RAM_W'(error), RAM_W'(!e.ok));
                check("out_cpu_reset", RAM_W'(cpu_reset), RAM_W'(!e.ok));
                check("out_ram", ram, e.ram);
                check("out_word_count", RAM_W'(word_count), RAM_W'(e.wc));
            end
        end
        flag_q <= done || error;
    end

    // Apply inputs now (at a falling edge) and return at the next falling edge
    task automatic drive(input logic v, input logic [7:0] d, input logic s);
        rx_valid = v;
        rx_data  = d;
        start    = s;
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] b[$], input logic [7:0] chk, input int max_gap,
                           input int gap_at, input int start_at);
        exp_t       e;
        logic [7:0] good;
        int         gaps;
        int         budget;
        logic [RAM_W-1:0] held;
        good   = xor_all(b);
        e.ram  = image(b, NBYTES);
        e.ok   = (chk == good);
        e.wc   = RAM_SIZE;
        exp_q.push_back(e);

        drive(1'b0, 8'($urandom), 1'b1);
        check("start_ram_clear", ram, '0);
        check("start_word_count", RAM_W'(word_count), '0);
        check("start_cpu_reset", RAM_W'(cpu_reset), RAM_W'(1'b1));
        check("start_rx_ready", RAM_W'(rx_ready), RAM_W'(1'b1));
        check("start_flags", RAM_W'({done, error}), '0);

        for (int i = 0; i < int'(NBYTES); i++) begin
            gaps = (i == gap_at) ? 3 : int'($urandom_range(0, max_gap));
            repeat (gaps) begin
                drive(1'b0, 8'($urandom), 1'b0);
                check("gap_word_count", RAM_W'(word_count), RAM_W'(i / 4));
                check("gap_ram", ram, image(b, i));
            end
            drive(1'b1, b[i], (i == start_at));
            check("byte_word_count", RAM_W'(word_count), RAM_W'((i + 1) / 4));
            check("byte_ram", ram, image(b, i + 1));
        end

        drive(1'b1, chk, 1'b0);
        check("chk_done", RAM_W'(done), RAM_W'(e.ok));
        check("chk_error", RAM_W'(error), RAM_W'(!e.ok));
        check("chk_rx_ready", RAM_W'(rx_ready), '0);

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            drive(1'b0, 8'h00, 1'b0);
            budget--;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL outcome_timeout actual pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end

        held = ram;
        repeat (3) begin
            drive(1'b1, 8'($urandom), 1'b0);
            check("hold_ram", ram, held);
            check("hold_flags", RAM_W'({done, error}), RAM_W'({e.ok, !e.ok}));
        end
    endtask

    initial begin
        logic [7:0] seq[$];
        logic [7:0] aa[$];
        logic [7:0] rb[$];
        logic [7:0] chk;

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < int'(NBYTES); i++) seq.push_back(8'(i + 1));
        for (int i = 0; i < int'(RAM_SIZE); i++) begin
            aa.push_back(8'hAA); aa.push_back(8'hBB); aa.push_back(8'hCC); aa.push_back(8'hDD);
        end

        @(negedge clk);
        drive(1'b1, 8'h55, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        check("rst_ram", ram, '0);
        check("rst_word_count", RAM_W'(word_count), '0);
        check("rst_cpu_reset", RAM_W'(cpu_reset), RAM_W'(1'b1));
        check("rst_flags", RAM_W'({done, error, rx_ready}), '0);

        drive(1'b1, 8'h77, 1'b0);
        check("idle_ignore_ram", ram, '0);

        do_load(seq, 8'h10, 0, -1, -1);
        do_load(seq, 8'h11, 0, -1, -1);
        do_load(seq, 8'h10, 0, 2, -1);

        // Abort mid-load with reset while a byte is also offered
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, seq[i], 1'b0);
        check("pre_rst_word_count", RAM_W'(word_count), RAM_W'(1));
        reset = 1'b1;
        drive(1'b1, 8'h07, 1'b1);
        reset = 1'b0;
        check("midrst_ram", ram, '0);
        check("midrst_word_count", RAM_W'(word_count), '0);
        check("midrst_cpu_reset", RAM_W'(cpu_reset), RAM_W'(1'b1));
        check("midrst_rx_ready", RAM_W'(rx_ready), '0);
        repeat (4) begin
            drive(1'b1, 8'($urandom), 1'b0);
            check("post_rst_ignore", RAM_W'({rx_ready, word_count}), '0);
            check("post_rst_ram", ram, '0);
        end

        do_load(seq, 8'h10, 0, -1, 5);
        do_load(aa, 8'h00, 0, -1, -1);

        for (int n = 0; n < 6; n++) begin
            rb.delete();
            for (int i = 0; i < int'(NBYTES); i++) rb.push_back(8'($urandom));
            chk = xor_all(rb);
            if ($urandom_range(0, 1) == 1) chk = chk ^ 8'($urandom_range(1, 255));
            do_load(rb, chk, 2, -1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NBYTES - 1)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
